// File: rtl/cp_corr_metric.sv
// cp_corr_metric: streaming cyclic-prefix correlator for OFDM timing/CFO.
//   lambda(k) = |gamma(k)| - (rho/2)*Phi(k), window L, lag N.
//   |gamma| is approximated as max + min/4 + min/8.
//   angle(gamma) comes from a pipelined vectoring CORDIC.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       sample strobe; every register advances only when 1
//   in_i, in_q     Q1.(SAMP_W-1) signed sample
//   out_valid      lambda_o/angle_o derive from N+L real samples
//   lambda_o       Q6.8 signed metric (saturated)
//   angle_o        Q3.8 signed radians
//   sat_o          sticky lambda-clip flag; present only when
//                  CP_CORR_SAT_FLAG_EN is defined
// Latency: CORDIC_STAGES+3 strobes from input to output.
module cp_corr_metric #(
    parameter int N             = 256,
    parameter int L             = 16,
    parameter int SAMP_W        = 8,
    parameter int RHO_RAW       = 128,
    parameter int CORDIC_STAGES = 8,
    parameter int LAMBDA_W      = 14,
    parameter int ANG_W         = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMP_W-1:0]   in_i,
    input  logic [SAMP_W-1:0]   in_q,
    output logic                out_valid,
    output logic [LAMBDA_W-1:0] lambda_o,
    output logic [ANG_W-1:0]    angle_o
`ifdef CP_CORR_SAT_FLAG_EN
    ,
    output logic                sat_o
`endif
);
    localparam int PW  = 2*SAMP_W + 2;        // product width
    localparam int GW  = PW + $clog2(L);      // moving-sum width
    localparam int CW  = GW + 2;              // CORDIC x/y (negation + gain)
    localparam int ZW  = ANG_W + 4;           // angle with 4 guard bits
    localparam int LF  = GW + 9;              // full-precision lambda
    localparam int SH  = 2*(SAMP_W-1) - 8;    // down to Q.8
    localparam int S   = CORDIC_STAGES;
    localparam int AW  = $clog2(N);
    localparam int LW  = $clog2(L);
    localparam int CNW = $clog2(N+L+1);
    localparam logic signed [LF-1:0] LMAX    = LF'(2**(LAMBDA_W-1) - 1);
    localparam logic signed [LF-1:0] LMIN    = ~LMAX;
    localparam logic signed [ZW-1:0] HALF_PI = ZW'(6434);

    // atan(2^-i) in Q3.12
    function automatic logic signed [ZW-1:0] atan_tab(input int i);
        case (i)
            0:  return ZW'(3217);
            1:  return ZW'(1899);
            2:  return ZW'(1003);
            3:  return ZW'(509);
            4:  return ZW'(256);
            5:  return ZW'(128);
            6:  return ZW'(64);
            7:  return ZW'(32);
            8:  return ZW'(16);
            9:  return ZW'(8);
            10: return ZW'(4);
            11: return ZW'(2);
            12: return ZW'(1);
            default: return '0;
        endcase
    endfunction

    // ---------------- lag buffer + products ----------------
    logic [SAMP_W-1:0]    lag_i [N];
    logic [SAMP_W-1:0]    lag_q [N];
    logic [AW-1:0]        wp;
    logic signed [PW-1:0] di, dq, xi, xq;
    logic signed [PW-1:0] p_r, p_i, p_e;

    assign di = PW'($signed(lag_i[wp]));
    assign dq = PW'($signed(lag_q[wp]));
    assign xi = PW'($signed(in_i));
    assign xq = PW'($signed(in_q));

    // read-before-write: the products use the old entry at wp
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                lag_i[j] <= '0;
                lag_q[j] <= '0;
            end
            wp  <= '0;
            p_r <= '0;
            p_i <= '0;
            p_e <= '0;
        end else if (in_valid) begin
            lag_i[wp] <= in_i;
            lag_q[wp] <= in_q;
            wp        <= wp + 1'b1;
            p_r       <= di*xi + dq*xq;
            p_i       <= dq*xi - di*xq;
            p_e       <= di*di + dq*dq + xi*xi + xq*xq;
        end
    end

    // ---------------- moving sums ----------------
    logic signed [PW-1:0] h_r [L];
    logic signed [PW-1:0] h_i [L];
    logic signed [PW-1:0] h_e [L];
    logic [LW-1:0]        lp;
    logic signed [GW-1:0] gr, gi, phi;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < L; j++) begin
                h_r[j] <= '0;
                h_i[j] <= '0;
                h_e[j] <= '0;
            end
            lp  <= '0;
            gr  <= '0;
            gi  <= '0;
            phi <= '0;
        end else if (in_valid) begin
            gr     <= gr  + GW'(p_r) - GW'(h_r[lp]);
            gi     <= gi  + GW'(p_i) - GW'(h_i[lp]);
            phi    <= phi + GW'(p_e) - GW'(h_e[lp]);
            h_r[lp] <= p_r;
            h_i[lp] <= p_i;
            h_e[lp] <= p_e;
            lp     <= lp + 1'b1;
        end
    end

    // ---------------- metric + CORDIC pre-rotation ----------------
    logic [GW-1:0]              agr, agi, amax, amin;
    logic [GW:0]                mag;
    logic [GW+7:0]              rp;
    logic signed [LF-1:0]       lam_full, lam_sh;
    logic                       clip;
    logic [LAMBDA_W-1:0]        lam_sat;
    logic signed [CW-1:0]       gre, gie, px, py;
    logic signed [ZW-1:0]       pz;

    always_comb begin
        agr = gr[GW-1] ? -gr : gr;
        agi = gi[GW-1] ? -gi : gi;
        if (agr >= agi) begin
            amax = agr;
            amin = agi;
        end else begin
            amax = agi;
            amin = agr;
        end
        mag      = (GW+1)'(amax) + (GW+1)'(amin >> 2) + (GW+1)'(amin >> 3);
        rp       = ((GW+8)'(RHO_RAW) * (GW+8)'($unsigned(phi))) >> 9;
        lam_full = $signed(LF'(mag)) - $signed(LF'(rp));
        lam_sh   = lam_full >>> SH;
        clip     = (lam_sh > LMAX) || (lam_sh < LMIN);
        if (!clip)              lam_sat = LAMBDA_W'(lam_sh);
        else if (lam_sh[LF-1])  lam_sat = LMIN[LAMBDA_W-1:0];
        else                    lam_sat = LMAX[LAMBDA_W-1:0];

        // fold left half-plane into the right so the CORDIC converges
        gre = CW'(gr);
        gie = CW'(gi);
        px  = gre;
        py  = gie;
        pz  = '0;
        if (gr < 0) begin
            if (gi >= 0) begin
                px = gie;
                py = -gre;
                pz = HALF_PI;
            end else begin
                px = -gie;
                py = gre;
                pz = -HALF_PI;
            end
        end
    end

    // ---------------- CORDIC pipe, lambda delay, outputs ----------------
    logic signed [CW-1:0]       cx [S+1];
    logic signed [CW-1:0]       cy [S+1];
    logic signed [ZW-1:0]       cz [S+1];
    logic [S:0]                 zf;       // gamma==0: force angle 0
    logic [LAMBDA_W-1:0]        lam_d [S+1];
    logic signed [ZW:0]         zr;
    logic [CNW-1:0]             cnt;
    logic [S+3:0]               vld_pipe;

    assign zr        = (ZW+1)'(cz[S]) + (ZW+1)'(8);  // round half-up
    assign out_valid = vld_pipe[S+3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= S; i++) begin
                cx[i]    <= '0;
                cy[i]    <= '0;
                cz[i]    <= '0;
                lam_d[i] <= '0;
            end
            zf       <= '0;
            cnt      <= '0;
            vld_pipe <= '0;
            lambda_o <= '0;
            angle_o  <= '0;
`ifdef CP_CORR_SAT_FLAG_EN
            sat_o    <= 1'b0;
`endif
        end else if (in_valid) begin
            cnt      <= (cnt == CNW'(N+L)) ? cnt : cnt + 1'b1;
            vld_pipe <= {vld_pipe[S+2:0], (cnt >= CNW'(N+L-1))};

            lam_d[0] <= lam_sat;
            cx[0]    <= px;
            cy[0]    <= py;
            cz[0]    <= pz;
            zf[0]    <= (gr == 0) && (gi == 0);
`ifdef CP_CORR_SAT_FLAG_EN
            if (clip) sat_o <= 1'b1;
`endif
            for (int i = 0; i < S; i++) begin
                if (cy[i] >= 0) begin
                    cx[i+1] <= cx[i] + (cy[i] >>> i);
                    cy[i+1] <= cy[i] - (cx[i] >>> i);
                    cz[i+1] <= cz[i] + atan_tab(i);
                end else begin
                    cx[i+1] <= cx[i] - (cy[i] >>> i);
                    cy[i+1] <= cy[i] + (cx[i] >>> i);
                    cz[i+1] <= cz[i] - atan_tab(i);
                end
                zf[i+1]    <= zf[i];
                lam_d[i+1] <= lam_d[i];
            end

            lambda_o <= lam_d[S];
            angle_o  <= zf[S] ? '0 : ANG_W'(zr >>> 4);
        end
    end
endmodule

// File: tb/tb_cp_corr_metric.sv
// Directed bench for cp_corr_metric. Two instances: default parameters
// (dut) and RHO_RAW=0 (dut_s) for the saturation case. Inputs are shared.
module tb_cp_corr_metric;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_i, in_q;
    logic        out_valid, s_out_valid;
    logic [13:0] lambda_o, s_lambda_o;
    logic [10:0] angle_o, s_angle_o;
`ifdef CP_CORR_SAT_FLAG_EN
    logic        sat_o, s_sat_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [13:0] ref_lam [$];
    logic [10:0] ref_ang [$];

    always #5 clk = ~clk;

    cp_corr_metric dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .out_valid(out_valid), .lambda_o(lambda_o), .angle_o(angle_o)
`ifdef CP_CORR_SAT_FLAG_EN
        , .sat_o(sat_o)
`endif
    );

    cp_corr_metric #(.RHO_RAW(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .out_valid(s_out_valid), .lambda_o(s_lambda_o), .angle_o(s_angle_o)
`ifdef CP_CORR_SAT_FLAG_EN
        , .sat_o(s_sat_o)
`endif
    );

    // one clock: drive, edge, sample 1ns later
    task automatic cyc(input logic v, input logic [7:0] i, input logic [7:0] q);
        in_valid = v;
        in_i     = i;
        in_q     = q;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'd0, 8'd0);
        rst = 1'b0;
    endtask

    function automatic int sang(input logic [10:0] a);
        return int'($signed(a));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 8'($urandom), 8'($urandom));
            total++;
            if ({out_valid, lambda_o, angle_o, s_out_valid, s_lambda_o, s_angle_o} !== '0) begin
                bad++;
                $display("FAIL reset_c%0d: got v=%b l=%0d a=%0d, want all 0",
                         c, out_valid, lambda_o, angle_o);
            end
        end
        rst = 1'b0;
    endtask

    // (64,0): gamma=(65536,0), Phi=131072 -> lambda=(65536-32768)>>6=512.
    // CORDIC residual for 8 stages is under 2 LSB, so angle within +-2 of 0.
    task automatic test_constant();
        int rise = 0, nb_l = 0, nb_a = 0, drops = 0;
        do_reset();
        ref_lam.delete();
        ref_ang.delete();
        for (int k = 1; k <= 400; k++) begin
            cyc(1'b1, 8'd64, 8'd0);
            if (out_valid === 1'b1) begin
                if (rise == 0) rise = k;
                ref_lam.push_back(lambda_o);
                ref_ang.push_back(angle_o);
                if (lambda_o !== 14'd512) nb_l++;
                if (sang(angle_o) < -2 || sang(angle_o) > 2) nb_a++;
            end else if (rise != 0) drops++;
        end
        total++;
        if (rise !== 283) begin bad++; $display("FAIL const_rise: got strobe %0d, want 283", rise); end
        total++;
        if (nb_l !== 0) begin bad++; $display("FAIL const_lambda: %0d samples off 512 (last %0d)", nb_l, lambda_o); end
        total++;
        if (nb_a !== 0) begin bad++; $display("FAIL const_angle: %0d samples outside +-2 (last %0d)", nb_a, sang(angle_o)); end
        total++;
        if (drops !== 0) begin bad++; $display("FAIL const_drop: out_valid fell %0d times, want 0", drops); end
    endtask

    // (64,0) then (0,64): rotated window gives gamma=(0,-65536) for output
    // strobes 283..523; later the window holds (0,64)x(0,64) -> gamma=(65536,0).
    task automatic test_quarter();
        int nb_v = 0, nb_l = 0, nb_a = 0;
        do_reset();
        for (int k = 1; k <= 556; k++) begin
            if (k <= 256) cyc(1'b1, 8'd64, 8'd0);
            else          cyc(1'b1, 8'd0, 8'd64);
            if (k >= 283 && k <= 523) begin
                if (out_valid !== 1'b1) nb_v++;
                if (lambda_o !== 14'd512) nb_l++;
                if (sang(angle_o) < -404 || sang(angle_o) > -400) nb_a++;
            end
        end
        total++;
        if (nb_v !== 0 || nb_l !== 0) begin
            bad++; $display("FAIL quarter_lambda: %0d invalid, %0d lambda off 512", nb_v, nb_l);
        end
        total++;
        if (nb_a !== 0) begin bad++; $display("FAIL quarter_angle: %0d samples outside -402+-2", nb_a); end
        total++;
        if (lambda_o !== 14'd512 || sang(angle_o) < -2 || sang(angle_o) > 2) begin
            bad++; $display("FAIL quarter_back: got l=%0d a=%0d, want 512 and 0+-2", lambda_o, sang(angle_o));
        end
    endtask

    task automatic test_stalls();
        int acc = 0, cycles = 0, rise = 0, idx = 0, nb = 0, holdbad = 0;
        logic v;
        logic [13:0] pl;
        logic [10:0] pa;
        logic pv;
        do_reset();
        while (acc < 400 && cycles < 3000) begin
            v  = 1'($urandom_range(0, 1));
            pl = lambda_o;
            pa = angle_o;
            pv = out_valid;
            cyc(v, 8'd64, 8'd0);
            cycles++;
            if (v) begin
                acc++;
                if (out_valid === 1'b1) begin
                    if (rise == 0) rise = acc;
                    if (idx >= ref_lam.size() || lambda_o !== ref_lam[idx] || angle_o !== ref_ang[idx]) nb++;
                    idx++;
                end
            end else if (lambda_o !== pl || angle_o !== pa || out_valid !== pv) holdbad++;
        end
        total++;
        if (acc !== 400) begin bad++; $display("FAIL stall_budget: accepted %0d, want 400", acc); end
        total++;
        if (rise !== 283) begin bad++; $display("FAIL stall_rise: got strobe %0d, want 283", rise); end
        total++;
        if (idx !== ref_lam.size() || nb !== 0) begin
            bad++; $display("FAIL stall_seq: got %0d outputs with %0d diffs, want %0d with 0", idx, nb, ref_lam.size());
        end
        total++;
        if (holdbad !== 0) begin bad++; $display("FAIL stall_hold: %0d idle cycles changed outputs, want 0", holdbad); end
    endtask

    // (-128,-128): gamma=(524288,0) -> 32.0 -> 8192, clips to 8191 at rho=0.
    // Default rho: Phi=1048576, lambda=(524288-262144)>>6=4096, no clip.
    task automatic test_saturation();
        do_reset();
`ifdef CP_CORR_SAT_FLAG_EN
        total++;
        if (s_sat_o !== 1'b0) begin bad++; $display("FAIL sat_flag_reset: got %b, want 0", s_sat_o); end
`endif
        for (int k = 1; k <= 400; k++) cyc(1'b1, 8'h80, 8'h80);
        total++;
        if (s_out_valid !== 1'b1 || s_lambda_o !== 14'd8191) begin
            bad++; $display("FAIL sat_clip: got v=%b l=%0d, want 1 and 8191", s_out_valid, s_lambda_o);
        end
        total++;
        if (lambda_o !== 14'd4096) begin bad++; $display("FAIL sat_fullscale: got %0d, want 4096", lambda_o); end
`ifdef CP_CORR_SAT_FLAG_EN
        total++;
        if (s_sat_o !== 1'b1 || sat_o !== 1'b0) begin
            bad++; $display("FAIL sat_flag_set: got s=%b d=%b, want 1 and 0", s_sat_o, sat_o);
        end
`endif
        for (int k = 1; k <= 300; k++) cyc(1'b1, 8'd64, 8'd0);
        total++;
        if (s_lambda_o !== 14'd1024) begin bad++; $display("FAIL sat_recover: got %0d, want 1024", s_lambda_o); end
`ifdef CP_CORR_SAT_FLAG_EN
        total++;
        if (s_sat_o !== 1'b1) begin bad++; $display("FAIL sat_flag_sticky: got %b, want 1", s_sat_o); end
        do_reset();
        total++;
        if (s_sat_o !== 1'b0) begin bad++; $display("FAIL sat_flag_clear: got %b, want 0", s_sat_o); end
`endif
    endtask

    task automatic test_midreset();
        int nb_r = 0, rise = 0;
        do_reset();
        for (int k = 1; k <= 150; k++) cyc(1'b1, 8'd64, 8'd0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc(1'b1, 8'($urandom), 8'($urandom));
            if ({out_valid, lambda_o, angle_o} !== '0) nb_r++;
        end
        rst = 1'b0;
        total++;
        if (nb_r !== 0) begin bad++; $display("FAIL mid_reset_zero: %0d cycles nonzero, want 0", nb_r); end
        for (int k = 1; k <= 400 && rise == 0; k++) begin
            cyc(1'b1, 8'd64, 8'd0);
            if (out_valid === 1'b1) rise = k;
        end
        total++;
        if (rise !== 283) begin bad++; $display("FAIL mid_rise: got strobe %0d, want 283", rise); end
        total++;
        if (lambda_o !== 14'd512) begin bad++; $display("FAIL mid_lambda: got %0d, want 512", lambda_o); end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_i     = '0;
        in_q     = '0;
        test_reset();
        test_constant();
        test_quarter();
        test_stalls();
        test_saturation();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
